// File: rtl/down_counter_if.sv
// Control/status bundle for down_counter: load/enable requests in, count/tc/busy out.
interface down_counter_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;

  modport master (
    output load, load_val, en,
    input  count, tc, busy
  );

  modport slave (
    input  load, load_val, en,
    output count, tc, busy
  );
endinterface

// File: rtl/down_counter.sv
// Loadable down counter with a registered one-cycle terminal-count pulse.
// Define DOWN_COUNTER_RELOAD_EN to auto-reload from the last loaded period instead of stopping at zero.
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  down_counter_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] count_reg;
  logic             tc_reg;
  logic             busy_reg;
`ifdef DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] period_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      tc_reg     <= 1'b0;
      busy_reg   <= 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
      period_reg <= '0;
`endif
    end else begin
      tc_reg <= 1'b0;
      if (bus.load) begin
        // Load wins over any pending decrement, so a restart never emits tc.
        count_reg <= bus.load_val;
`ifdef DOWN_COUNTER_RELOAD_EN
        period_reg <= bus.load_val;
`endif
        if (bus.load_val != '0) begin
          state_reg <= RUN;
          busy_reg  <= 1'b1;
        end else begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= IDLE;
          end
          RUN: begin
            if (bus.en) begin
              if (count_reg > WIDTH'(1)) begin
                count_reg <= count_reg - WIDTH'(1);
              end else begin
                // RUN only holds non-zero counts, so this is the count=1 terminal step.
                tc_reg <= 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
                count_reg <= period_reg;
`else
                count_reg <= '0;
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
`endif
              end
            end
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.count = count_reg;
  assign bus.tc    = tc_reg;
  assign bus.busy  = busy_reg;

endmodule

// File: tb/tb_down_counter.sv
// Directed-vector bench for down_counter; expectations are hand-computed per cycle.
// Expectations adapt when DOWN_COUNTER_RELOAD_EN is defined.
module tb_down_counter;

  localparam int WIDTH = 8;
`ifdef DOWN_COUNTER_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  down_counter_if #(.WIDTH(WIDTH)) bus ();

  down_counter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One clock edge, then compare all three outputs away from the edge.
  task automatic tick(input string tag, input int exp_count, input bit exp_tc, input bit exp_busy);
    @(posedge clk);
    #1;
    $display("%s: load=%0d val=%0d en=%0d rst=%0d -> count=%0d tc=%0d busy=%0d",
             tag, bus.load, bus.load_val, bus.en, rst, bus.count, bus.tc, bus.busy);
    check({tag, ".count"}, 32'(bus.count), 32'(exp_count));
    check({tag, ".tc"},    32'(bus.tc),    32'(exp_tc));
    check({tag, ".busy"},  32'(bus.busy),  32'(exp_busy));
  endtask

  task automatic drive(input bit ld, input int val, input bit e);
    bus.load     = ld;
    bus.load_val = WIDTH'(val);
    bus.en       = e;
  endtask

  initial begin
    // Reset overrides a simultaneous load and enable.
    rst = 1'b1;
    drive(1'b1, 5, 1'b1);
    tick("rst0", 0, 1'b0, 1'b0);
    tick("rst1", 0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic countdown from 3.
    drive(1'b1, 3, 1'b0);
    tick("basic_load", 3, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b1);
    tick("basic_d1", 2, 1'b0, 1'b1);
    tick("basic_d2", 1, 1'b0, 1'b1);
    tick("basic_tc", RELOAD ? 3 : 0, 1'b1, RELOAD);
    tick("basic_after", RELOAD ? 2 : 0, 1'b0, RELOAD);

    // Enable gaps: en pattern 1,0,0,1,1,0,1 after loading 4.
    drive(1'b1, 4, 1'b0);
    tick("gap_load", 4, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b1); tick("gap_e1", 3, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0); tick("gap_e2", 3, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0); tick("gap_e3", 3, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b1); tick("gap_e4", 2, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b1); tick("gap_e5", 1, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0); tick("gap_e6", 1, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b1); tick("gap_e7", RELOAD ? 4 : 0, 1'b1, RELOAD);

    // Restart mid-run and load priority over the terminal decrement.
    drive(1'b1, 5, 1'b0);
    tick("rs_load5", 5, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b1);
    tick("rs_d1", 4, 1'b0, 1'b1);
    tick("rs_d2", 3, 1'b0, 1'b1);
    tick("rs_d3", 2, 1'b0, 1'b1);
    drive(1'b1, 10, 1'b1);
    tick("rs_load10", 10, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b1);
    for (int i = 9; i >= 1; i--) tick("rs_run", i, 1'b0, 1'b1);
    drive(1'b1, 7, 1'b1);
    tick("rs_prio", 7, 1'b0, 1'b1);

    // Load of zero goes idle; en is then ignored.
    drive(1'b1, 0, 1'b0);
    tick("zero_load", 0, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b1);
    tick("zero_idle_en", 0, 1'b0, 1'b0);
    tick("zero_idle_en2", 0, 1'b0, 1'b0);

    // Full-range period: tc exactly 255 enabled cycles after loading 8'hFF.
    drive(1'b1, 255, 1'b0);
    tick("ff_load", 255, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b1);
    for (int i = 254; i >= 1; i--) tick("ff_run", i, 1'b0, 1'b1);
    tick("ff_tc", RELOAD ? 255 : 0, 1'b1, RELOAD);

    // Reset in cycle 100 of a countdown aborts with no tc.
    drive(1'b1, 255, 1'b0);
    tick("ab_load", 255, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b1);
    for (int i = 254; i >= 157; i--) tick("ab_run", i, 1'b0, 1'b1);
    rst = 1'b1;
    tick("ab_rst", 0, 1'b0, 1'b0);
    rst = 1'b0;
    tick("ab_post", 0, 1'b0, 1'b0);

`ifdef DOWN_COUNTER_RELOAD_EN
    // Auto-reload: three periods of 3 with busy held high.
    drive(1'b1, 3, 1'b0);
    tick("rl_load", 3, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b1);
    for (int p = 0; p < 3; p++) begin
      tick("rl_d2", 2, 1'b0, 1'b1);
      tick("rl_d1", 1, 1'b0, 1'b1);
      tick("rl_tc", 3, 1'b1, 1'b1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
